// File: rtl/nios2_ocimem_pkg.sv
// Shared encodings for the OCI RAM JTAG/CPU arbiter: JTAG op codes, IR value,
// FSM states and grant identities.
package nios2_ocimem_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 32;

  // JTAG op field cmd_jdo[37:36]
  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  localparam logic [1:0] IR_OCIMEM = 2'b00;

  typedef enum logic [1:0] {
    StIdle,
    StCpuRd,
    StJtagRd
  } state_e;

  typedef enum logic {
    GNT_CPU,
    GNT_JTAG
  } grant_e;

  function automatic logic is_ram_op(input logic [1:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/nios2_ocimem_rr_arb.sv
// Two-requester round-robin arbiter; on a conflict the requester that did not
// win last time is granted. last_grant resets to JTAG so the CPU wins first.
module nios2_ocimem_rr_arb
  import nios2_ocimem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic cpu_req,
  input  logic jtag_req,
  output logic gnt_cpu,
  output logic gnt_jtag
);

  grant_e last_q, last_d;

  always_comb begin
    gnt_cpu  = 1'b0;
    gnt_jtag = 1'b0;
    last_d   = last_q;
    if (enable) begin
      if (cpu_req && jtag_req) begin
        if (last_q == GNT_JTAG) begin
          gnt_cpu = 1'b1;
        end else begin
          gnt_jtag = 1'b1;
        end
      end else if (cpu_req) begin
        gnt_cpu = 1'b1;
      end else if (jtag_req) begin
        gnt_jtag = 1'b1;
      end
    end
    if (gnt_cpu) begin
      last_d = GNT_CPU;
    end else if (gnt_jtag) begin
      last_d = GNT_JTAG;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= GNT_JTAG;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/nios2_ocimem_jtag_cpu_arbiter.sv
// Sequences JTAG ocimem commands (load address, write/read with auto-increment)
// and shares the single-port OCI RAM with CPU debug-slave accesses.
module nios2_ocimem_jtag_cpu_arbiter
  import nios2_ocimem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_ir,
  input  logic [37:0]       cmd_jdo,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic              ram_rd,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] mon_dreg,
  output logic              mon_ready,
  output logic              mon_error,
  output logic [ADDR_W-1:0] jtag_addr
);

  state_e            state_q, state_d;
  logic              pending_q, pending_d;
  logic              jwrite_q, jwrite_d;
  logic [DATA_W-1:0] jwdata_q, jwdata_d;
  logic [ADDR_W-1:0] jtag_addr_q, jtag_addr_d;
  logic [DATA_W-1:0] mon_dreg_q, mon_dreg_d;
  logic              mon_ready_q, mon_ready_d;
  logic              mon_error_q, mon_error_d;
  logic [DATA_W-1:0] avs_rdata_q, avs_rdata_d;

  logic       cpu_req;
  logic       gnt_cpu, gnt_jtag;
  logic       arb_en;
  logic       is_cmd, busy, accept, overrun;
  logic [1:0] jop;
  logic       unused_jdo;

  assign unused_jdo = ^cmd_jdo[35:32];

  assign cpu_req = avs_read | avs_write;
  assign arb_en  = (state_q == StIdle) && !reset;
  assign jop     = cmd_jdo[37:36];
  assign is_cmd  = cmd_valid && (cmd_ir == IR_OCIMEM);
  // A pending op that wins the RAM this cycle frees the slot for a new command.
  assign busy    = (pending_q && !gnt_jtag) || (state_q == StJtagRd);
  assign accept  = is_cmd && !busy;
  assign overrun = is_cmd && busy;

  nios2_ocimem_rr_arb u_arb (
    .clk      (clk),
    .reset    (reset),
    .enable   (arb_en),
    .cpu_req  (cpu_req),
    .jtag_req (pending_q),
    .gnt_cpu  (gnt_cpu),
    .gnt_jtag (gnt_jtag)
  );

  always_comb begin
    ram_addr  = '0;
    ram_wr    = 1'b0;
    ram_rd    = 1'b0;
    ram_wdata = '0;
    if (gnt_cpu) begin
      ram_addr  = avs_address;
      ram_wr    = avs_write;
      ram_rd    = !avs_write;
      ram_wdata = avs_writedata;
    end else if (gnt_jtag) begin
      ram_addr  = jtag_addr_q;
      ram_wr    = jwrite_q;
      ram_rd    = !jwrite_q;
      ram_wdata = jwdata_q;
    end
  end

  assign avs_waitrequest = cpu_req && !((gnt_cpu && avs_write) || (state_q == StCpuRd));

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    jwrite_d    = jwrite_q;
    jwdata_d    = jwdata_q;
    jtag_addr_d = jtag_addr_q;
    mon_dreg_d  = mon_dreg_q;
    mon_ready_d = mon_ready_q;
    mon_error_d = mon_error_q;
    avs_rdata_d = avs_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (gnt_cpu && !avs_write) begin
          state_d = StCpuRd;
        end
        if (gnt_jtag) begin
          pending_d = 1'b0;
          if (jwrite_q) begin
            mon_ready_d = 1'b1;
            jtag_addr_d = jtag_addr_q + ADDR_W'(1);
          end else begin
            state_d = StJtagRd;
          end
        end
      end
      StCpuRd: begin
        avs_rdata_d = ram_rdata;
        state_d     = StIdle;
      end
      StJtagRd: begin
        mon_dreg_d  = ram_rdata;
        // A command accepted in the read's grant cycle is still outstanding.
        mon_ready_d = !pending_q;
        jtag_addr_d = jtag_addr_q + ADDR_W'(1);
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (overrun) begin
      mon_error_d = 1'b1;
    end

    // Applied last so a newly accepted command overrides a completing one.
    if (accept) begin
      if (jop == OP_LOAD) begin
        jtag_addr_d = cmd_jdo[ADDR_W-1:0];
        mon_error_d = 1'b0;
      end else if (is_ram_op(jop)) begin
        pending_d   = 1'b1;
        mon_ready_d = 1'b0;
        jwrite_d    = (jop == OP_WRITE);
        jwdata_d    = cmd_jdo[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pending_q   <= 1'b0;
      jwrite_q    <= 1'b0;
      jwdata_q    <= '0;
      jtag_addr_q <= '0;
      mon_dreg_q  <= '0;
      mon_ready_q <= 1'b1;
      mon_error_q <= 1'b0;
      avs_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      jwrite_q    <= jwrite_d;
      jwdata_q    <= jwdata_d;
      jtag_addr_q <= jtag_addr_d;
      mon_dreg_q  <= mon_dreg_d;
      mon_ready_q <= mon_ready_d;
      mon_error_q <= mon_error_d;
      avs_rdata_q <= avs_rdata_d;
    end
  end

  assign avs_readdata = avs_rdata_q;
  assign mon_dreg     = mon_dreg_q;
  assign mon_ready    = mon_ready_q;
  assign mon_error    = mon_error_q;
  assign jtag_addr    = jtag_addr_q;

endmodule

// File: tb/tb_nios2_ocimem_jtag_cpu_arbiter.sv
// Directed bench for the OCI RAM JTAG/CPU arbiter with a behavioural
// single-port RAM (1-cycle read latency) and a backdoor preload port.
module tb_nios2_ocimem_jtag_cpu_arbiter;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_jdo;
  logic [7:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_wr;
  logic        ram_rd;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] mon_dreg;
  logic        mon_ready;
  logic        mon_error;
  logic [7:0]  jtag_addr;

  logic [31:0] mem [256] = '{default: 32'h0};
  logic        bd_we = 1'b0;
  logic [7:0]  bd_addr = 8'h0;
  logic [31:0] bd_data = 32'h0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nios2_ocimem_jtag_cpu_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ir          (cmd_ir),
    .cmd_jdo         (cmd_jdo),
    .avs_address     (avs_address),
    .avs_read        (avs_read),
    .avs_write       (avs_write),
    .avs_writedata   (avs_writedata),
    .avs_readdata    (avs_readdata),
    .avs_waitrequest (avs_waitrequest),
    .ram_addr        (ram_addr),
    .ram_wr          (ram_wr),
    .ram_rd          (ram_rd),
    .ram_wdata       (ram_wdata),
    .ram_rdata       (ram_rdata),
    .mon_dreg        (mon_dreg),
    .mon_ready       (mon_ready),
    .mon_error       (mon_error),
    .jtag_addr       (jtag_addr)
  );

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_wr) mem[ram_addr] <= ram_wdata;
    if (ram_rd) ram_rdata <= mem[ram_addr];
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    cyc();
    bd_we = 1'b0;
  endtask

  // Drives a one-cycle ocimem command; returns 1 ns after the following negedge.
  task automatic jcmd(input logic [1:0] op, input logic [31:0] payload);
    cmd_valid = 1'b1; cmd_ir = 2'b00; cmd_jdo = {op, 4'b0, payload};
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc();
    avs_read = 1'b1; avs_address = 8'h33; #1;
    n_vec++; if (avs_waitrequest !== 1'b1)
      begin n_err++; $display("FAIL rst_waitreq got=%0h want=1", avs_waitrequest); end
    n_vec++; if (ram_rd !== 1'b0 || ram_wr !== 1'b0 || ram_addr !== 8'h00)
      begin n_err++; $display("FAIL rst_ram_quiet rd=%0h wr=%0h addr=%0h want 0/0/0",
                              ram_rd, ram_wr, ram_addr); end
    avs_read = 1'b0; #1;
    n_vec++; if (mon_ready !== 1'b1 || mon_error !== 1'b0)
      begin n_err++; $display("FAIL rst_mon ready=%0h err=%0h want 1/0", mon_ready, mon_error); end
    n_vec++; if (mon_dreg !== 32'h0 || avs_readdata !== 32'h0 || jtag_addr !== 8'h0)
      begin n_err++; $display("FAIL rst_regs dreg=%0h rdata=%0h jaddr=%0h want 0/0/0",
                              mon_dreg, avs_readdata, jtag_addr); end
    n_vec++; if (avs_waitrequest !== 1'b0)
      begin n_err++; $display("FAIL rst_waitreq_idle got=%0h want=0", avs_waitrequest); end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_cpu_write();
    avs_write = 1'b1; avs_address = 8'h60; avs_writedata = 32'h12345678; #1;
    n_vec++; if (ram_wr !== 1'b1 || ram_addr !== 8'h60 || ram_wdata !== 32'h12345678)
      begin n_err++; $display("FAIL cpu_wr_grant wr=%0h addr=%0h data=%0h want 1/60/12345678",
                              ram_wr, ram_addr, ram_wdata); end
    n_vec++; if (avs_waitrequest !== 1'b0)
      begin n_err++; $display("FAIL cpu_wr_wait got=%0h want=0", avs_waitrequest); end
    cyc();
    avs_write = 1'b0; #1;
    n_vec++; if (mem[8'h60] !== 32'h12345678)
      begin n_err++; $display("FAIL cpu_wr_mem got=%0h want=12345678", mem[8'h60]); end
  endtask

  task automatic test_write();
    jcmd(OP_LOAD, 32'h10);
    n_vec++; if (jtag_addr !== 8'h10)
      begin n_err++; $display("FAIL wr_load got=%0h want=10", jtag_addr); end
    jcmd(OP_WRITE, 32'hDEADBEEF);
    n_vec++; if (ram_wr !== 1'b1 || ram_addr !== 8'h10 || ram_wdata !== 32'hDEADBEEF)
      begin n_err++; $display("FAIL wr_grant wr=%0h addr=%0h data=%0h want 1/10/deadbeef",
                              ram_wr, ram_addr, ram_wdata); end
    n_vec++; if (mon_ready !== 1'b0)
      begin n_err++; $display("FAIL wr_busy got=%0h want=0", mon_ready); end
    cyc();
    n_vec++; if (mon_ready !== 1'b1 || jtag_addr !== 8'h11 || ram_wr !== 1'b0)
      begin n_err++; $display("FAIL wr_done ready=%0h jaddr=%0h wr=%0h want 1/11/0",
                              mon_ready, jtag_addr, ram_wr); end
    n_vec++; if (mem[8'h10] !== 32'hDEADBEEF)
      begin n_err++; $display("FAIL wr_mem got=%0h want=deadbeef", mem[8'h10]); end
  endtask

  task automatic test_read();
    preload(8'h10, 32'hDEADBEEF);
    jcmd(OP_LOAD, 32'h10);
    jcmd(OP_READ, 32'h0);
    n_vec++; if (ram_rd !== 1'b1 || ram_addr !== 8'h10 || ram_wr !== 1'b0)
      begin n_err++; $display("FAIL rd_grant rd=%0h addr=%0h wr=%0h want 1/10/0",
                              ram_rd, ram_addr, ram_wr); end
    cyc();
    n_vec++; if (mon_ready !== 1'b0 || ram_rd !== 1'b0)
      begin n_err++; $display("FAIL rd_wait ready=%0h rd=%0h want 0/0", mon_ready, ram_rd); end
    cyc();
    n_vec++; if (mon_dreg !== 32'hDEADBEEF || mon_ready !== 1'b1 || jtag_addr !== 8'h11)
      begin n_err++; $display("FAIL rd_done dreg=%0h ready=%0h jaddr=%0h want deadbeef/1/11",
                              mon_dreg, mon_ready, jtag_addr); end
  endtask

  task automatic test_wrap();
    jcmd(OP_LOAD, 32'hFF);
    jcmd(OP_WRITE, 32'h1);
    n_vec++; if (ram_wr !== 1'b1 || ram_addr !== 8'hFF)
      begin n_err++; $display("FAIL wrap_first wr=%0h addr=%0h want 1/ff", ram_wr, ram_addr); end
    jcmd(OP_WRITE, 32'h2);
    n_vec++; if (ram_wr !== 1'b1 || ram_addr !== 8'h00 || ram_wdata !== 32'h2)
      begin n_err++; $display("FAIL wrap_second wr=%0h addr=%0h data=%0h want 1/0/2",
                              ram_wr, ram_addr, ram_wdata); end
    n_vec++; if (mon_error !== 1'b0)
      begin n_err++; $display("FAIL wrap_no_err got=%0h want=0", mon_error); end
    cyc();
    n_vec++; if (jtag_addr !== 8'h01 || mon_ready !== 1'b1)
      begin n_err++; $display("FAIL wrap_addr jaddr=%0h ready=%0h want 1/1", jtag_addr, mon_ready); end
    n_vec++; if (mem[8'hFF] !== 32'h1 || mem[8'h00] !== 32'h2)
      begin n_err++; $display("FAIL wrap_mem ff=%0h 00=%0h want 1/2", mem[8'hFF], mem[8'h00]); end
  endtask

  task automatic test_back_to_back();
    preload(8'h20, 32'hCAFE0020);
    jcmd(OP_LOAD, 32'h40);
    jcmd(OP_WRITE, 32'h11111111);
    // Both requesting, JTAG won last: CPU read goes first.
    avs_read = 1'b1; avs_address = 8'h20; #1;
    n_vec++; if (ram_rd !== 1'b1 || ram_wr !== 1'b0 || ram_addr !== 8'h20)
      begin n_err++; $display("FAIL rr_cpu1 rd=%0h wr=%0h addr=%0h want 1/0/20",
                              ram_rd, ram_wr, ram_addr); end
    n_vec++; if (avs_waitrequest !== 1'b1)
      begin n_err++; $display("FAIL rr_cpu1_wait got=%0h want=1", avs_waitrequest); end
    cyc();
    n_vec++; if (avs_waitrequest !== 1'b0 || ram_wr !== 1'b0 || ram_rd !== 1'b0)
      begin n_err++; $display("FAIL rr_cpurd wait=%0h wr=%0h rd=%0h want 0/0/0",
                              avs_waitrequest, ram_wr, ram_rd); end
    cyc();
    n_vec++; if (avs_readdata !== 32'hCAFE0020)
      begin n_err++; $display("FAIL rr_rdata1 got=%0h want=cafe0020", avs_readdata); end
    cmd_valid = 1'b1; cmd_ir = 2'b00; cmd_jdo = {OP_WRITE, 4'b0, 32'h22222222}; #1;
    n_vec++; if (ram_wr !== 1'b1 || ram_addr !== 8'h40 || ram_wdata !== 32'h11111111)
      begin n_err++; $display("FAIL rr_jtag1 wr=%0h addr=%0h data=%0h want 1/40/11111111",
                              ram_wr, ram_addr, ram_wdata); end
    n_vec++; if (avs_waitrequest !== 1'b1)
      begin n_err++; $display("FAIL rr_jtag1_wait got=%0h want=1", avs_waitrequest); end
    @(negedge clk);
    cmd_valid = 1'b0; #1;
    n_vec++; if (ram_rd !== 1'b1 || ram_wr !== 1'b0 || ram_addr !== 8'h20)
      begin n_err++; $display("FAIL rr_cpu2 rd=%0h wr=%0h addr=%0h want 1/0/20",
                              ram_rd, ram_wr, ram_addr); end
    n_vec++; if (mon_error !== 1'b0 || mon_ready !== 1'b0)
      begin n_err++; $display("FAIL rr_accept err=%0h ready=%0h want 0/0", mon_error, mon_ready); end
    cyc();
    n_vec++; if (avs_waitrequest !== 1'b0)
      begin n_err++; $display("FAIL rr_cpu2_done got=%0h want=0", avs_waitrequest); end
    cyc();
    avs_read = 1'b0; #1;
    n_vec++; if (ram_wr !== 1'b1 || ram_addr !== 8'h41 || ram_wdata !== 32'h22222222)
      begin n_err++; $display("FAIL rr_jtag2 wr=%0h addr=%0h data=%0h want 1/41/22222222",
                              ram_wr, ram_addr, ram_wdata); end
    cyc();
    n_vec++; if (mem[8'h40] !== 32'h11111111 || mem[8'h41] !== 32'h22222222)
      begin n_err++; $display("FAIL rr_mem 40=%0h 41=%0h want 11111111/22222222",
                              mem[8'h40], mem[8'h41]); end
    n_vec++; if (jtag_addr !== 8'h42 || mon_ready !== 1'b1)
      begin n_err++; $display("FAIL rr_end jaddr=%0h ready=%0h want 42/1", jtag_addr, mon_ready); end
  endtask

  task automatic test_overrun();
    preload(8'h30, 32'h5A5A5A5A);
    preload(8'h31, 32'h0000ABCD);
    jcmd(OP_LOAD, 32'h30);
    jcmd(OP_READ, 32'h0);
    cyc();
    jcmd(OP_WRITE, 32'h77);
    n_vec++; if (mon_error !== 1'b1)
      begin n_err++; $display("FAIL ovr_flag got=%0h want=1", mon_error); end
    n_vec++; if (mon_dreg !== 32'h5A5A5A5A || mon_ready !== 1'b1 || jtag_addr !== 8'h31)
      begin n_err++; $display("FAIL ovr_read dreg=%0h ready=%0h jaddr=%0h want 5a5a5a5a/1/31",
                              mon_dreg, mon_ready, jtag_addr); end
    n_vec++; if (ram_wr !== 1'b0)
      begin n_err++; $display("FAIL ovr_nowr1 got=%0h want=0", ram_wr); end
    cyc();
    n_vec++; if (ram_wr !== 1'b0 || mem[8'h31] !== 32'h0000ABCD)
      begin n_err++; $display("FAIL ovr_nowr2 wr=%0h mem31=%0h want 0/abcd", ram_wr, mem[8'h31]); end
    jcmd(OP_LOAD, 32'h05);
    n_vec++; if (mon_error !== 1'b0 || jtag_addr !== 8'h05)
      begin n_err++; $display("FAIL ovr_clear err=%0h jaddr=%0h want 0/05", mon_error, jtag_addr); end
  endtask

  task automatic test_reset_mid();
    jcmd(OP_LOAD, 32'h50);
    jcmd(OP_READ, 32'h0);
    cyc();
    reset = 1'b1; #1;
    n_vec++; if (ram_rd !== 1'b0 || ram_wr !== 1'b0)
      begin n_err++; $display("FAIL rstm_quiet rd=%0h wr=%0h want 0/0", ram_rd, ram_wr); end
    cyc();
    reset = 1'b0; #1;
    n_vec++; if (mon_ready !== 1'b1 || mon_dreg !== 32'h0 || jtag_addr !== 8'h0)
      begin n_err++; $display("FAIL rstm_regs ready=%0h dreg=%0h jaddr=%0h want 1/0/0",
                              mon_ready, mon_dreg, jtag_addr); end
    n_vec++; if (ram_rd !== 1'b0 || ram_wr !== 1'b0)
      begin n_err++; $display("FAIL rstm_after rd=%0h wr=%0h want 0/0", ram_rd, ram_wr); end
    cyc();
    n_vec++; if (ram_rd !== 1'b0 || ram_wr !== 1'b0 || mon_ready !== 1'b1)
      begin n_err++; $display("FAIL rstm_after2 rd=%0h wr=%0h ready=%0h want 0/0/1",
                              ram_rd, ram_wr, mon_ready); end
  endtask

  task automatic test_ir_ignored();
    cmd_valid = 1'b1; cmd_ir = 2'b01; cmd_jdo = {OP_LOAD, 4'b0, 32'h77};
    @(negedge clk);
    cmd_ir = 2'b10; cmd_jdo = {OP_WRITE, 4'b0, 32'h99};
    @(negedge clk);
    cmd_valid = 1'b0; cmd_ir = 2'b00; #1;
    n_vec++; if (jtag_addr !== 8'h00 || mon_ready !== 1'b1 || ram_wr !== 1'b0)
      begin n_err++; $display("FAIL ir_ignored jaddr=%0h ready=%0h wr=%0h want 0/1/0",
                              jtag_addr, mon_ready, ram_wr); end
    jcmd(OP_NOP, 32'h0);
    n_vec++; if (mon_ready !== 1'b1 || ram_wr !== 1'b0 || ram_rd !== 1'b0)
      begin n_err++; $display("FAIL nop ready=%0h wr=%0h rd=%0h want 1/0/0",
                              mon_ready, ram_wr, ram_rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_ir = 2'b00; cmd_jdo = '0;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    test_reset();
    test_cpu_write();
    test_write();
    test_read();
    test_wrap();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_ir_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
